// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy block: gate state encoding,
// default sizing constants and a ceiling-log2 helper for timer sizing.
package parking_pkg;

    typedef enum logic {
        G_CLOSED = 1'b0,
        G_OPEN   = 1'b1
    } gate_state_t;

    localparam int unsigned DEF_CAPACITY     = 16;
    localparam int unsigned DEF_GATE_TIMEOUT = 1000;

    // Smallest r such that 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < longint'(v)) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector with one previous-value register.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; the previous-value register loads the
//           live input so a level held across reset release is not an event
//   x     - sampled input
//   ev_c  - combinational one-cycle event: x high now, low last cycle
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic ev_c
);

    logic x_q;

    // Previous value tracks the input in and out of reset alike.
    always_ff @(posedge clk) begin
        x_q <= x;
    end

    // No events are reported while reset is asserted.
    assign ev_c = x & ~x_q & ~reset;

endmodule

// File: rtl/parking_occupancy.sv
// Parking lot occupancy tracker and entry-gate controller.
// Counts cars from the entry/exit sensor pulses, reports full/empty, keeps
// sticky overflow/underflow flags and opens the entry barrier on a ticket
// request while space is free.
// Optional feature macro: PARKING_TIMEOUT_EN compiles in a gate auto-close
// timer of GATE_TIMEOUT cycles; without it the timeout output is tied 0.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   car_in, car_out  - sensor levels; each rising edge is one car in / out
//   req              - ticket button; each rising edge is one request
//   gate_open        - barrier open command (registered)
//   count            - current occupancy (registered)
//   full, empty      - count == CAPACITY / count == 0 (registered)
//   err_ovf, err_unf - sticky entry-while-full / exit-while-empty flags
//   timeout          - one-cycle pulse when the gate auto-closes
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY     = DEF_CAPACITY,
    parameter int unsigned CNT_W        = 5,
    parameter int unsigned GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_in,
    input  logic             car_out,
    input  logic             req,
    output logic             gate_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_unf,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);

    // Illegal parameter combinations leave a visible marker in the hierarchy.
    if (((64'(1) << CNT_W) <= 64'(CAPACITY)) || (GATE_TIMEOUT == 0)) begin : g_bad_params
    end

    logic ev_in;
    logic ev_out;
    logic ev_req;

    rise_det u_det_in (
        .clk   (clk),
        .reset (reset),
        .x     (car_in),
        .ev_c  (ev_in)
    );

    rise_det u_det_out (
        .clk   (clk),
        .reset (reset),
        .x     (car_out),
        .ev_c  (ev_out)
    );

    rise_det u_det_req (
        .clk   (clk),
        .reset (reset),
        .x     (req),
        .ev_c  (ev_req)
    );

    // Occupancy next-value: simultaneous in/out cancel with no error.
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_set;
    logic             unf_set;

    always_comb begin
        count_nxt = count;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (ev_in && !ev_out) begin
            if (count == CAP_V) begin
                ovf_set = 1'b1;
            end else begin
                count_nxt = count + CNT_W'(1);
            end
        end else if (ev_out && !ev_in) begin
            if (count == '0) begin
                unf_set = 1'b1;
            end else begin
                count_nxt = count - CNT_W'(1);
            end
        end
    end

    // Occupancy registers; flags derive from the next count to stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            count   <= count_nxt;
            full    <= (count_nxt == CAP_V);
            empty   <= (count_nxt == '0);
            err_ovf <= err_ovf | ovf_set;
            err_unf <= err_unf | unf_set;
        end
    end

    gate_state_t state;
    gate_state_t state_nxt;

`ifdef PARKING_TIMEOUT_EN
    localparam int unsigned TMR_RAW = clog2(GATE_TIMEOUT);
    localparam int unsigned TMR_W   = (TMR_RAW == 0) ? 1 : TMR_RAW;

    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             timeout_nxt;
`endif

    // Gate state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= G_CLOSED;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate next-state: open on a request only if the lot will not be full.
    always_comb begin
        state_nxt = state;
        case (state)
            G_CLOSED: begin
                if (ev_req && (count_nxt < CAP_V)) begin
                    state_nxt = G_OPEN;
                end
            end
            G_OPEN: begin
                if (ev_in) begin
                    state_nxt = G_CLOSED;
                end
`ifdef PARKING_TIMEOUT_EN
                else if (timer == '0) begin
                    state_nxt = G_CLOSED;
                end
`endif
            end
            default: state_nxt = G_CLOSED;
        endcase
    end

`ifdef PARKING_TIMEOUT_EN
    // Gate outputs and timer: load on opening, count down while open; a car
    // entering on the expiry cycle closes the gate without a timeout pulse.
    always_comb begin
        timer_nxt   = timer;
        timeout_nxt = 1'b0;
        if (state == G_CLOSED) begin
            if (state_nxt == G_OPEN) begin
                timer_nxt = TMR_W'(GATE_TIMEOUT - 1);
            end
        end else begin
            if (timer != '0) begin
                timer_nxt = timer - TMR_W'(1);
            end else if (!ev_in) begin
                timeout_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_open <= 1'b0;
            timer     <= '0;
            timeout   <= 1'b0;
        end else begin
            gate_open <= (state_nxt == G_OPEN);
            timer     <= timer_nxt;
            timeout   <= timeout_nxt;
        end
    end
`else
    // Gate output register; no auto-close in this build.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_open <= 1'b0;
        end else begin
            gate_open <= (state_nxt == G_OPEN);
        end
    end

    assign timeout = 1'b0;
`endif

endmodule
